vigna_coproc_issue: RTL and testbench
=====================================

# vigna_coproc_issue

Core-side initiator for the coprocessor valid/ready interface. Accepts one decoded M-extension request at a time from the execute stage and drives `valid/func/id/op1/op2` to the coprocessor (`vigna_m_ext`). It holds all request fields stable until the coprocessor's one-cycle `ready` pulse, captures `result`, and presents it on a writeback handshake. It also supports pipeline flush and a sticky timeout flag.

## Interface
- `TIMEOUT`, default 96: busy-cycle limit before `cp_timeout` sets; must be greater than 40 (worst coprocessor latency).
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_valid` input 1: execute stage presents a request.
- `req_ready` output 1: block can accept; high only in IDLE.
- `req_func` input 3: M-extension funct3 (000 MUL … 111 REMU).
- `req_rd` input 5: destination register.
- `req_op1`, `req_op2` input 32: rs1 and rs2 values.
- `flush` input 1: kill the in-flight or pending writeback.
- `cp_valid` output 1: request to coprocessor.
- `cp_ready` input 1: coprocessor completion pulse, one cycle.
- `cp_func` output 3; `cp_id` output 3; `cp_op1`, `cp_op2` output 32: held request fields.
- `cp_result` input 32: valid only in the cycle where `cp_ready`=1.
- `wb_valid` output 1; `wb_ready` input 1: writeback handshake.
- `wb_rd` output 5; `wb_id` output 3; `wb_data` output 32.
- `busy` output 1: state is not IDLE.
- `cp_timeout` output 1: sticky error flag, cleared only by reset.

## Operation
- States: IDLE, BUSY, WB, KILL.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid && !flush`: register func, rd, op1 and op2 into the `cp_*` and holding registers. Set `cp_valid`<=1. Go to BUSY.
  - `req_valid && flush` in the same cycle: request is not accepted; stay in IDLE.
- **BUSY**
  - `cp_valid`=1. All `cp_*` fields are frozen, because the coprocessor re-reads op1, op2 and func during computation.
  - On `cp_ready`:
    - `cp_valid`<=0.
    - `wb_data`<=`cp_result`.
    - `cp_id`<=`cp_id`+1 (wraps modulo 8).
    - Go to WB.
  - On `flush` without `cp_ready`: go to KILL. The coprocessor cannot be aborted.
  - `flush` and `cp_ready` in the same cycle: capture is suppressed, `cp_valid`<=0, id increments, go to IDLE.
  - Busy counter:
    - 8-bit, increments each BUSY/KILL cycle and saturates.
    - Cleared on entry to BUSY.
    - When it reaches `TIMEOUT`, `cp_timeout`<=1. The block keeps waiting.
- **KILL**
  - `cp_valid` and fields held exactly as in BUSY.
  - On `cp_ready`: `cp_valid`<=0, discard the result, id increments, go to IDLE.
  - `flush` has no further effect.
- **WB**
  - `wb_valid`=1; `wb_rd`, `wb_id`, `wb_data` stable.
  - On `wb_ready`: go to IDLE.
  - On `flush` (with or without `wb_ready`): `wb_valid` drops and the block goes to IDLE. No writeback is counted as taken when flush wins.
- `wb_id` is the `cp_id` value used for that operation, captured before the increment.
- Stray `cp_ready` in IDLE or WB: ignored; `cp_timeout`<=1 to flag the protocol error.
- Reset mid-operation: the block returns to IDLE immediately. After reset the system must also reset the coprocessor.

## Timing
- Reset values:
  - 0: `cp_valid`, `wb_valid`, `busy`, `cp_timeout`, `cp_func`, `cp_id`, `cp_op1`, `cp_op2`, `wb_rd`, `wb_id`, `wb_data`.
  - 1: `req_ready`.
- All outputs are registered, except `req_ready` and `busy`, which decode state directly.
- Accept edge A: `cp_valid` is high from A. The coprocessor samples it at A+1.
- Completion:
  - `cp_ready` sampled high at edge R: `cp_valid` low from R, `wb_valid` high from R.
  - The coprocessor is back in its idle state after R and must see `cp_valid`=0 at R+1; this rule guarantees that.
- Minimum `cp_valid` low gap between operations is 1 cycle. WB followed by IDLE already enforces it, so back-to-back issue never re-triggers the coprocessor.
- Block overhead beyond coprocessor latency is 2 cycles (accept to `cp_valid`, and ready to `wb_valid`).
- With `wb_ready` tied high, issue-to-issue spacing is coprocessor latency + 3.

## Test plan
- MUL 7×6, `rd`=5, model coprocessor ready after 34 cycles, `wb_ready`=1: expect `wb_valid` 1 cycle with `wb_data`=42, `wb_rd`=5, `wb_id`=0; the next op gets id 1.
- DIVU 100/7 followed immediately by REMU 100/7: expect `wb_data` 14 then 2, `cp_valid` low at least 1 cycle between ops, and `cp_op1/op2` unchanged for the full BUSY span.
- `wb_ready` held low 10 cycles after completion: `wb_valid` and `wb_data` stable, `req_ready`=0 throughout; release, then IDLE in 1 cycle.
- `flush` 5 cycles into BUSY: `cp_valid` stays high until `cp_ready`, no `wb_valid` ever, then IDLE; `flush` coincident with `cp_ready`: no writeback, IDLE next cycle.
- Coprocessor stalled 200 cycles with `TIMEOUT`=96: `cp_timeout` rises after 96 BUSY cycles; a late ready still completes the writeback; the flag persists until reset.
- `resetn` asserted low mid-BUSY: all outputs return to their reset values asynchronously; stray `cp_ready` in IDLE sets `cp_timeout` and produces no `wb_valid`.

Source files
------------

// File: rtl/vigna_coproc_issue_if.sv
// Signal bundle between the execute stage, the coprocessor issue block,
// the vigna_m_ext coprocessor and the writeback stage.
interface vigna_coproc_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic [4:0]  req_rd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        flush;

  logic        cp_valid;
  logic        cp_ready;
  logic [2:0]  cp_func;
  logic [2:0]  cp_id;
  logic [31:0] cp_op1;
  logic [31:0] cp_op2;
  logic [31:0] cp_result;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_id;
  logic [31:0] wb_data;

  logic        busy;
  logic        cp_timeout;

  // master: the issue block itself
  modport master (
    input  req_valid, req_func, req_rd, req_op1, req_op2, flush,
           cp_ready, cp_result, wb_ready,
    output req_ready, cp_valid, cp_func, cp_id, cp_op1, cp_op2,
           wb_valid, wb_rd, wb_id, wb_data, busy, cp_timeout
  );

  // slave: execute stage, coprocessor and writeback seen as one environment
  modport slave (
    output req_valid, req_func, req_rd, req_op1, req_op2, flush,
           cp_ready, cp_result, wb_ready,
    input  req_ready, cp_valid, cp_func, cp_id, cp_op1, cp_op2,
           wb_valid, wb_rd, wb_id, wb_data, busy, cp_timeout
  );
endinterface

// File: rtl/vigna_coproc_issue.sv
// Core-side initiator for the M-extension coprocessor: holds one request
// stable until the completion pulse, then offers the result for writeback.
module vigna_coproc_issue #(
  parameter int TIMEOUT = 96
) (
  input  logic                 clk,
  input  logic                 resetn,
  vigna_coproc_issue_if.master io
);

  typedef enum logic [1:0] {IDLE, BUSY, WB, KILL} state_t;

  typedef struct packed {
    logic [2:0]  func;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        cp_valid_q, cp_valid_d;
  logic [2:0]  cp_id_q, cp_id_d;
  logic        wb_valid_q, wb_valid_d;
  logic [2:0]  wb_id_q, wb_id_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic [7:0]  cnt_inc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cp_valid_q <= 1'b0;
      cp_id_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cp_valid_q <= cp_valid_d;
      cp_id_q    <= cp_id_d;
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
    end
  end

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cp_valid_d = cp_valid_q;
    cp_id_d    = cp_id_q;
    wb_valid_d = wb_valid_q;
    wb_id_d    = wb_id_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    case (state_q)
      IDLE: begin
        if (io.cp_ready) to_d = 1'b1;
        if (io.req_valid && !io.flush) begin
          req_d.func = io.req_func;
          req_d.rd   = io.req_rd;
          req_d.op1  = io.req_op1;
          req_d.op2  = io.req_op2;
          cp_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY, KILL: begin
        cnt_d = cnt_inc;
        if ({1'b0, cnt_inc} >= TO_LIM) to_d = 1'b1;
        // The coprocessor cannot be aborted, so a flush only decides
        // whether its eventual result is kept or dropped.
        if (io.cp_ready) begin
          cp_valid_d = 1'b0;
          cp_id_d    = cp_id_q + 3'd1;
          if (state_q == BUSY && !io.flush) begin
            wb_valid_d = 1'b1;
            wb_data_d  = io.cp_result;
            wb_id_d    = cp_id_q;
            state_d    = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == BUSY && io.flush) begin
          state_d = KILL;
        end
      end
      WB: begin
        if (io.cp_ready) to_d = 1'b1;
        if (io.wb_ready || io.flush) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.busy       = (state_q != IDLE);
  assign io.cp_valid   = cp_valid_q;
  assign io.cp_func    = req_q.func;
  assign io.cp_id      = cp_id_q;
  assign io.cp_op1     = req_q.op1;
  assign io.cp_op2     = req_q.op2;
  assign io.wb_valid   = wb_valid_q;
  assign io.wb_rd      = req_q.rd;
  assign io.wb_id      = wb_id_q;
  assign io.wb_data    = wb_data_q;
  assign io.cp_timeout = to_q;

endmodule

// File: tb/tb_vigna_coproc_issue.sv
// Directed bench for vigna_coproc_issue: the bench plays execute stage,
// coprocessor and writeback; expected writebacks go through a scoreboard.
module tb_vigna_coproc_issue;
  logic clk = 1'b0;
  logic resetn;

  vigna_coproc_issue_if bus();
  vigna_coproc_issue #(.TIMEOUT(96)) dut (.clk(clk), .resetn(resetn), .io(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        scb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  nid;
  logic [2:0]  cur_f;
  logic [31:0] cur_a, cur_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cp_valid"}, bus.cp_valid, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_cp_timeout"}, bus.cp_timeout, 0);
    chk({tag, "_cp_func"}, bus.cp_func, 0);
    chk({tag, "_cp_id"}, bus.cp_id, 0);
    chk({tag, "_cp_op1"}, bus.cp_op1, 0);
    chk({tag, "_cp_op2"}, bus.cp_op2, 0);
    chk({tag, "_wb_rd"}, bus.wb_rd, 0);
    chk({tag, "_wb_id"}, bus.wb_id, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit keep);
    int t = 0;
    exp_t e;
    while (!bus.req_ready && t < 50) begin step(); t++; end
    chk("req_ready_before_issue", bus.req_ready, 1);
    chk("cp_valid_gap", bus.cp_valid, 0);
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_rd    = rd;
    bus.req_op1   = a;
    bus.req_op2   = b;
    step();
    bus.req_valid = 1'b0;
    bus.req_op1   = 32'h5555_AAAA;
    bus.req_op2   = 32'hAAAA_5555;
    chk("cp_valid_after_accept", bus.cp_valid, 1);
    chk("cp_func_id", {bus.cp_func, bus.cp_id}, {f, nid});
    cur_f = f; cur_a = a; cur_b = b;
    if (keep) begin
      e.rd = rd; e.id = nid; e.data = mext(f, a, b);
      scb.push_back(e);
    end
  endtask

  // cp_valid and every request field must stay frozen while the op is in flight
  task automatic hold(input string tag, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      ok &= (bus.cp_valid === 1'b1) && (bus.cp_func === cur_f) && (bus.cp_op1 === cur_a)
         && (bus.cp_op2 === cur_b) && (bus.wb_valid === 1'b0) && (bus.busy === 1'b1);
      step();
    end
    chk(tag, ok, 1);
  endtask

  // coprocessor completion: result is computed from what the DUT presents
  task automatic pulse(input bit fl);
    bus.cp_ready  = 1'b1;
    bus.cp_result = mext(bus.cp_func, bus.cp_op1, bus.cp_op2);
    bus.flush     = fl;
    step();
    bus.cp_ready  = 1'b0;
    bus.cp_result = 32'hDEAD_BEEF;
    bus.flush     = 1'b0;
    nid++;
  endtask

  task automatic take();
    exp_t e;
    chk("wb_valid_on_done", bus.wb_valid, 1);
    chk("cp_valid_drop_on_done", bus.cp_valid, 0);
    chk("scb_nonempty", (scb.size() != 0), 1);
    if (scb.size() != 0) begin
      e = scb.pop_front();
      chk("wb_data", bus.wb_data, e.data);
      chk("wb_rd", bus.wb_rd, e.rd);
      chk("wb_id", bus.wb_id, e.id);
    end
    step();
    chk("wb_valid_one_cycle", bus.wb_valid, 0);
    chk("idle_after_wb", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] d;
    resetn = 1'b0;
    bus.req_valid = 0; bus.req_func = 0; bus.req_rd = 0; bus.req_op1 = 0; bus.req_op2 = 0;
    bus.flush = 0; bus.cp_ready = 0; bus.cp_result = 0; bus.wb_ready = 0;
    nid = 0;
    step(2);
    chk_reset("por");
    resetn = 1'b1;
    step();

    // MUL 7x6 -> rd 5, coprocessor latency 34, wb_ready tied high
    bus.wb_ready = 1'b1;
    issue(3'd0, 5'd5, 32'd7, 32'd6, 1);
    hold("mul_hold", 33);
    pulse(0);
    chk("mul_data", bus.wb_data, 32'd42);
    take();

    // DIVU then REMU back to back
    issue(3'd5, 5'd3, 32'd100, 32'd7, 1);
    hold("divu_hold", 20);
    pulse(0);
    chk("divu_data", bus.wb_data, 32'd14);
    take();
    issue(3'd7, 5'd4, 32'd100, 32'd7, 1);
    hold("remu_hold", 20);
    pulse(0);
    chk("remu_data", bus.wb_data, 32'd2);
    take();

    // writeback back-pressure for 10 cycles
    bus.wb_ready = 1'b0;
    issue(3'd1, 5'd9, 32'hFFFF_FFFD, 32'd5, 1);
    hold("mulh_hold", 10);
    pulse(0);
    d = bus.wb_data;
    chk("mulh_data", d, 32'hFFFF_FFFF);
    ok = 1'b1;
    repeat (10) begin
      ok &= (bus.wb_valid === 1'b1) && (bus.wb_data === d) && (bus.req_ready === 1'b0);
      step();
    end
    chk("wb_stall_stable", ok, 1);
    bus.wb_ready = 1'b1;
    take();

    // flush 5 cycles into BUSY: op runs to completion, result dropped
    issue(3'd4, 5'd1, 32'd50, 32'hFFFF_FFF9, 0);
    hold("pre_flush_hold", 4);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    hold("kill_hold", 6);
    pulse(0);
    chk("kill_cp_valid", bus.cp_valid, 0);
    chk("kill_no_wb", bus.wb_valid, 0);
    chk("kill_idle", bus.busy, 0);
    step();
    chk("kill_no_wb_late", bus.wb_valid, 0);

    // flush coincident with the completion pulse
    issue(3'd6, 5'd2, 32'hFFFF_FFEC, 32'd6, 0);
    hold("coinc_hold", 8);
    pulse(1);
    chk("coinc_no_wb", bus.wb_valid, 0);
    chk("coinc_idle", bus.req_ready, 1);
    chk("coinc_cp_valid", bus.cp_valid, 0);

    // stalled coprocessor: timeout after 96 busy cycles, late ready still completes
    chk("timeout_clear_before_stall", bus.cp_timeout, 0);
    issue(3'd3, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    ok = 1'b1;
    for (int k = 0; k < 199; k++) begin
      if (k == 95) chk("timeout_not_yet", bus.cp_timeout, 0);
      if (k == 96) chk("timeout_set", bus.cp_timeout, 1);
      ok &= (bus.cp_valid === 1'b1) && (bus.cp_op1 === cur_a);
      step();
    end
    chk("stall_hold", ok, 1);
    pulse(0);
    chk("mulhu_data", bus.wb_data, 32'hFFFF_FFFE);
    take();
    step(3);
    chk("timeout_sticky", bus.cp_timeout, 1);

    // asynchronous reset mid-BUSY
    issue(3'd0, 5'd8, 32'd3, 32'd3, 0);
    hold("pre_reset_hold", 5);
    #2 resetn = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    resetn = 1'b1;
    nid = 0;
    step();

    // stray completion in IDLE is a protocol error, never a writeback
    bus.cp_ready  = 1'b1;
    bus.cp_result = 32'd123;
    step();
    bus.cp_ready  = 1'b0;
    chk("stray_timeout", bus.cp_timeout, 1);
    chk("stray_no_wb", bus.wb_valid, 0);
    chk("stray_idle", bus.busy, 0);
    chk("stray_id", bus.cp_id, 0);
    step();
    chk("stray_no_wb_late", bus.wb_valid, 0);

    chk("scb_drained", scb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
